dumpoff_seq: RTL and testbench

DUMPOFF_SEQ -- requirements
Module: dumpoff_seq

---
 rtl/dumpoff_pkg.sv | 49 ++++
 rtl/dumpoff_cnt.sv | 31 +++
 rtl/dumpoff_seq.sv | 188 ++++++++++++++++++
 tb/tb_dumpoff_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dumpoff_pkg.sv
// Shared definitions for the dump-off pulse sequencer: FSM state encoding,
// parameter defaults and round-robin channel selection helpers.
package dumpoff_pkg;

   localparam int DEF_N_CH  = 2;
   localparam int DEF_CNT_W = 16;

   // Widest supported channel mask; the helpers below work on this width
   // and the top zero-extends its own mask into it.
   localparam int MAX_CH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_PULSE = 2'd2,
      ST_GAP   = 2'd3
   } dumpoff_state_t;

   // One-hot of the lowest set bit of mask (all zero for an empty mask).
   function automatic logic [MAX_CH-1:0] rr_first(input logic [MAX_CH-1:0] mask);
      logic [MAX_CH-1:0] res;
      res = '0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (mask[i]) res = MAX_CH'(1) << i;
      end
      return res;
   endfunction

   // One-hot of the next set bit of mask strictly above the one-hot cur,
   // wrapping around; returns cur's own bit when it is the only one set.
   function automatic logic [MAX_CH-1:0] rr_next(input logic [MAX_CH-1:0] mask,
                                                 input logic [MAX_CH-1:0] cur);
      logic [MAX_CH-1:0] res;
      logic [2:0]        idx;
      logic [2:0]        pos;
      res = '0;
      idx = '0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (cur[i]) idx = 3'(i);
      end
      // Walk from the farthest candidate to the nearest so the nearest wins.
      for (int k = MAX_CH; k >= 1; k--) begin
         pos = 3'(int'(idx) + k);
         if (mask[pos]) res = MAX_CH'(1) << pos;
      end
      return res;
   endfunction

endpackage

// File: rtl/dumpoff_cnt.sv
// Loadable down-counter shared by the delay, pulse-width and gap phases.
// It saturates at zero and reports both "zero" and "at most one".
module dumpoff_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero,
   output logic             o_last
);

   logic [CNT_W-1:0] r_cnt;

   // Load has priority over decrement; decrement never wraps below zero.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);
   assign o_last = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/dumpoff_seq.sv
// Dump-off pulse sequencer. A rising edge on state_start launches a burst:
// a delay of D cycles, then R pulses of W cycles separated by G low cycles,
// driven on all enabled channels together or one channel per pulse in
// round-robin order. abort or rst stop a burst at once without done.
//
// Timing reference: t0 is the edge that accepts the start. The delay
// counter is loaded with D at t0 and the first pulse rises on the edge
// where it reads zero (t0+1+D). Width and gap counters are loaded with
// W / max(G,1) on the edge that enters the phase, and the phase ends on
// the edge where they read one, giving exactly W high and G low cycles.
module dumpoff_seq
   import dumpoff_pkg::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic             state_start,
   input  logic             abort,
   input  logic [CNT_W-1:0] delay_cfg,
   input  logic [CNT_W-1:0] width_cfg,
   input  logic [CNT_W-1:0] gap_cfg,
   input  logic [7:0]       repeat_cfg,
   input  logic [N_CH-1:0]  ch_en,
   input  logic             rr_mode,
   output logic [N_CH-1:0]  dumpoff,
   output logic             busy,
   output logic             done,
   output dumpoff_state_t   dbg_state
);

   dumpoff_state_t   r_state;
   logic             r_prev_start;
   logic [N_CH-1:0]  r_dumpoff;
   logic             r_done;
   logic [CNT_W-1:0] r_width;
   logic [CNT_W-1:0] r_gap;
   logic [7:0]       r_left;
   logic [N_CH-1:0]  r_mask;
   logic             r_rr;
   logic [MAX_CH-1:0] r_rr_cur;

   logic              w_start;
   logic              w_cnt_load;
   logic [CNT_W-1:0]  w_cnt_val;
   logic              w_cnt_dec;
   logic              w_cnt_zero;
   logic              w_cnt_last;
   logic [MAX_CH-1:0] w_mask8;
   logic [MAX_CH-1:0] w_first;
   logic [MAX_CH-1:0] w_next;

   assign w_start = state_start & ~r_prev_start;
   assign w_mask8 = MAX_CH'(r_mask);
   assign w_first = rr_first(w_mask8);
   assign w_next  = rr_next(w_mask8, r_rr_cur);

   dumpoff_cnt #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .i_clk      (clk_sys),
      .i_rst      (rst),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero),
      .o_last     (w_cnt_last)
   );

   // Counter control: load at each phase entry, otherwise count the phase down.
   always_comb begin
      w_cnt_load = 1'b0;
      w_cnt_val  = '0;
      w_cnt_dec  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start && !abort) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = delay_cfg;
            end
         end
         ST_DELAY: begin
            if (w_cnt_zero) begin
               w_cnt_load = (r_width != '0);
               w_cnt_val  = r_width;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         ST_PULSE: begin
            if (w_cnt_last) begin
               w_cnt_load = (r_left > 8'd1);
               w_cnt_val  = r_gap;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         ST_GAP: begin
            if (w_cnt_last) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = r_width;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         default: begin
            w_cnt_load = 1'b0;
         end
      endcase
   end

   // Burst FSM with registered pulse and done outputs; abort beats everything but reset.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_prev_start <= 1'b1;
         r_dumpoff    <= '0;
         r_done       <= 1'b0;
         r_width      <= '0;
         r_gap        <= '0;
         r_left       <= '0;
         r_mask       <= '0;
         r_rr         <= 1'b0;
         r_rr_cur     <= '0;
      end else begin
         r_prev_start <= state_start;
         r_done       <= 1'b0;
         if (abort) begin
            r_state   <= ST_IDLE;
            r_dumpoff <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_start) begin
                     r_width <= width_cfg;
                     r_gap   <= (gap_cfg == '0) ? CNT_W'(1) : gap_cfg;
                     r_left  <= (repeat_cfg == 8'd0) ? 8'd1 : repeat_cfg;
                     r_mask  <= ch_en;
                     r_rr    <= rr_mode;
                     r_state <= ST_DELAY;
                  end
               end
               ST_DELAY: begin
                  if (w_cnt_zero) begin
                     if (r_width == '0) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state   <= ST_PULSE;
                        r_rr_cur  <= w_first;
                        r_dumpoff <= r_rr ? w_first[N_CH-1:0] : r_mask;
                     end
                  end
               end
               ST_PULSE: begin
                  if (w_cnt_last) begin
                     r_dumpoff <= '0;
                     if (r_left <= 8'd1) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= ST_GAP;
                        r_left  <= r_left - 8'd1;
                     end
                  end
               end
               ST_GAP: begin
                  if (w_cnt_last) begin
                     r_state   <= ST_PULSE;
                     r_rr_cur  <= w_next;
                     r_dumpoff <= r_rr ? w_next[N_CH-1:0] : r_mask;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign dumpoff   = r_dumpoff;
   assign done      = r_done;
   assign busy      = (r_state != ST_IDLE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_dumpoff_seq.sv
// Self-checking bench for dumpoff_seq. Expected waveforms come from a
// closed-form model of the burst (pulse k rises at t0+1+D+k*(W+G')).
module tb_dumpoff_seq;
   import dumpoff_pkg::*;

   localparam int N_CH  = 2;
   localparam int CNT_W = 16;

   logic             clk_sys;
   logic             rst;
   logic             state_start;
   logic             abort;
   logic [CNT_W-1:0] delay_cfg;
   logic [CNT_W-1:0] width_cfg;
   logic [CNT_W-1:0] gap_cfg;
   logic [7:0]       repeat_cfg;
   logic [N_CH-1:0]  ch_en;
   logic             rr_mode;
   logic [N_CH-1:0]  dumpoff;
   logic             busy;
   logic             done;
   dumpoff_state_t   dbg_state;

   int errors = 0;
   int checks = 0;

   dumpoff_seq #(
      .N_CH (N_CH),
      .CNT_W(CNT_W)
   ) dut (
      .clk_sys    (clk_sys),
      .rst        (rst),
      .state_start(state_start),
      .abort      (abort),
      .delay_cfg  (delay_cfg),
      .width_cfg  (width_cfg),
      .gap_cfg    (gap_cfg),
      .repeat_cfg (repeat_cfg),
      .ch_en      (ch_en),
      .rr_mode    (rr_mode),
      .dumpoff    (dumpoff),
      .busy       (busy),
      .done       (done),
      .dbg_state  (dbg_state)
   );

   // Clock
   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Advance one edge and settle; outputs then reflect that edge.
   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   // Channel pattern of pulse k.
   function automatic logic [N_CH-1:0] exp_chan(input logic [N_CH-1:0] mask,
                                                 input logic rr, input int k);
      logic [N_CH-1:0] res;
      int pc;
      int j;
      res = '0;
      if (!rr) return mask;
      pc = $countones(mask);
      if (pc == 0) return '0;
      j = k % pc;
      for (int i = 0; i < N_CH; i++) begin
         if (mask[i]) begin
            if (j == 0) res[i] = 1'b1;
            j = j - 1;
         end
      end
      return res;
   endfunction

   // Expected dumpoff after the edge rel cycles past t0.
   function automatic logic [N_CH-1:0] exp_dump(input int rel, input int d, input int w,
                                                 input int g, input int r,
                                                 input logic [N_CH-1:0] mask, input logic rr);
      int geff, reff, per, off, k;
      geff = (g == 0) ? 1 : g;
      reff = (r == 0) ? 1 : r;
      per  = w + geff;
      if (w == 0 || rel < 1 + d) return '0;
      off = rel - 1 - d;
      k   = off / per;
      if (k >= reff) return '0;
      if ((off % per) < w) return exp_chan(mask, rr, k);
      return '0;
   endfunction

   function automatic int exp_done_rel(input int d, input int w, input int g, input int r);
      int geff, reff;
      geff = (g == 0) ? 1 : g;
      reff = (r == 0) ? 1 : r;
      if (w == 0) return 1 + d;
      return 1 + d + (reff - 1) * (w + geff) + w;
   endfunction

   // Drive a full burst and compare every cycle; configs are scrambled after
   // t0 and state_start wiggles mid-burst. chain=1 leaves a start edge ready
   // for the cycle right after done; chain=0 puts a start edge on done itself.
   task automatic run_burst(input int d, input int w, input int g, input int r,
                            input logic [N_CH-1:0] mask, input logic rr,
                            input bit chain, input string name);
      int done_rel;
      logic [N_CH-1:0] ed;
      done_rel    = exp_done_rel(d, w, g, r);
      delay_cfg   = CNT_W'(d);
      width_cfg   = CNT_W'(w);
      gap_cfg     = CNT_W'(g);
      repeat_cfg  = 8'(r);
      ch_en       = mask;
      rr_mode     = rr;
      state_start = 1'b1;
      for (int rel = 0; rel <= done_rel; rel++) begin
         step();
         ed = exp_dump(rel, d, w, g, r, mask, rr);
         checks++;
         if (dumpoff !== ed) begin
            errors++;
            $display("FAIL %s dumpoff rel=%0d got=%b exp=%b", name, rel, dumpoff, ed);
         end
         checks++;
         if (done !== (rel == done_rel)) begin
            errors++;
            $display("FAIL %s done rel=%0d got=%b exp=%b", name, rel, done, (rel == done_rel));
         end
         checks++;
         if (busy !== (rel < done_rel)) begin
            errors++;
            $display("FAIL %s busy rel=%0d got=%b exp=%b", name, rel, busy, (rel < done_rel));
         end
         if (rel == done_rel) begin
            checks++;
            if (dbg_state !== ST_IDLE) begin
               errors++;
               $display("FAIL %s state_at_done got=%0d exp=%0d", name, dbg_state, ST_IDLE);
            end
         end
         delay_cfg  = CNT_W'($urandom);
         width_cfg  = CNT_W'($urandom);
         gap_cfg    = CNT_W'($urandom);
         repeat_cfg = 8'($urandom);
         ch_en      = N_CH'($urandom);
         rr_mode    = 1'($urandom);
         if (rel + 1 > done_rel) state_start = 1'b0;
         else if (rel + 1 == done_rel) state_start = chain ? 1'b0 : 1'b1;
         else if (rel + 2 == done_rel && !chain) state_start = 1'b0;
         else state_start = 1'($urandom_range(0, 1));
      end
      if (!chain) begin
         for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || dumpoff !== '0) begin
               errors++;
               $display("FAIL %s idle_after_done cyc=%0d busy=%b done=%b dumpoff=%b exp=0/0/0",
                        name, i, busy, done, dumpoff);
            end
            state_start = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; state_start = 1'b1; abort = 1'b0;
      delay_cfg = '0; width_cfg = 16'd1; gap_cfg = '0; repeat_cfg = 8'd1;
      ch_en = '1; rr_mode = 1'b0;
      repeat (3) step();
      checks++;
      if (dumpoff !== '0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state dumpoff=%b busy=%b done=%b state=%0d exp=0/0/0/0",
                  dumpoff, busy, done, dbg_state);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (busy !== 1'b0 || dumpoff !== '0) begin
            errors++;
            $display("FAIL reset_high_level cyc=%0d busy=%b dumpoff=%b exp=0/00", i, busy, dumpoff);
         end
      end
      state_start = 1'b0;
      step();
   endtask

   task automatic test_spec_vectors();
      run_burst(3, 4, 2, 2, 2'b11, 1'b0, 1'b0, "basic");
      run_burst(0, 1, 1, 3, 2'b11, 1'b1, 1'b0, "rr");
      run_burst(2, 0, 3, 5, 2'b11, 1'b0, 1'b0, "w0");
      run_burst(2, 3, 1, 2, 2'b00, 1'b1, 1'b0, "mask0");
      run_burst(1, 2, 0, 0, 2'b10, 1'b0, 1'b0, "g0r0");
   endtask

   task automatic test_back_to_back();
      run_burst(1, 2, 0, 2, 2'b10, 1'b1, 1'b1, "b2b_a");
      run_burst(0, 1, 2, 3, 2'b01, 1'b0, 1'b1, "b2b_b");
      run_burst(0, 0, 0, 1, 2'b11, 1'b0, 1'b0, "b2b_c");
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         run_burst($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 3),
                   $urandom_range(0, 4), N_CH'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
      end
   endtask

   task automatic test_abort();
      delay_cfg = 16'd1; width_cfg = 16'd4; gap_cfg = 16'd2; repeat_cfg = 8'd3;
      ch_en = 2'b11; rr_mode = 1'b0; state_start = 1'b1;
      // Second pulse occupies rel 8..11; abort is sampled at rel 9.
      for (int rel = 0; rel <= 8; rel++) begin
         step();
         checks++;
         if (dumpoff !== exp_dump(rel, 1, 4, 2, 3, 2'b11, 1'b0)) begin
            errors++;
            $display("FAIL abort_pre rel=%0d got=%b exp=%b", rel, dumpoff,
                     exp_dump(rel, 1, 4, 2, 3, 2'b11, 1'b0));
         end
      end
      abort = 1'b1;
      step();
      checks++;
      if (dumpoff !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_edge dumpoff=%b busy=%b done=%b exp=00/0/0", dumpoff, busy, done);
      end
      abort = 1'b0;
      state_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || dumpoff !== '0) begin
            errors++;
            $display("FAIL abort_after cyc=%0d done=%b busy=%b dumpoff=%b exp=0/0/00",
                     i, done, busy, dumpoff);
         end
      end
      // Abort coincident with a start edge wins.
      abort = 1'b1; state_start = 1'b1;
      step();
      abort = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_vs_start busy=%b exp=0", busy);
      end
      state_start = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      delay_cfg = 16'd0; width_cfg = 16'd3; gap_cfg = 16'd1; repeat_cfg = 8'd4;
      ch_en = 2'b11; rr_mode = 1'b0; state_start = 1'b1;
      for (int rel = 0; rel <= 2; rel++) begin
         step();
         checks++;
         if (dumpoff !== exp_dump(rel, 0, 3, 1, 4, 2'b11, 1'b0)) begin
            errors++;
            $display("FAIL rstmid_pre rel=%0d got=%b exp=%b", rel, dumpoff,
                     exp_dump(rel, 0, 3, 1, 4, 2'b11, 1'b0));
         end
      end
      rst = 1'b1;
      step();
      checks++;
      if (dumpoff !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_edge dumpoff=%b busy=%b done=%b exp=00/0/0", dumpoff, busy, done);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || dumpoff !== '0) begin
            errors++;
            $display("FAIL rstmid_after cyc=%0d busy=%b done=%b dumpoff=%b exp=0/0/00",
                     i, busy, done, dumpoff);
         end
      end
      state_start = 1'b0;
      step();
      state_start = 1'b1;
      step();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_restart busy=%b exp=1", busy);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      state_start = 1'b0;
      step();
   endtask

   task automatic test_long_delay();
      run_burst(65535, 1, 0, 1, 2'b01, 1'b0, 1'b0, "long_delay");
   endtask

   initial begin
      test_reset();
      test_spec_vectors();
      test_back_to_back();
      test_random();
      test_abort();
      test_reset_mid();
      test_long_delay();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
